// File: rtl/spring_engine_arbiter_pkg.sv
// Shared types and defaults for the spring-engine arbiter slice.
// Holds the arbiter state encoding and the index-wrap helper.
package spring_engine_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      START  = 2'd1,
      BUSY   = 2'd2,
      FINISH = 2'd3
   } arb_state_t;

   localparam int NUM_REQ_DEF        = 2;
   localparam int NUM_NODES_DEF      = 10;
   localparam int FORCE_SIZE_DEF     = 8;
   localparam int TIMEOUT_CYCLES_DEF = 64;

   function automatic int wrap_inc(input int idx, input int modulus);
      return ((idx + 1) >= modulus) ? 0 : (idx + 1);
   endfunction

endpackage

// File: rtl/spring_engine_arbiter_if.sv
// Bundle between the step sequencer / spring engine and the arbiter.
// The arbiter takes the slave view; the sequencer+engine side takes the master view.
interface spring_engine_arbiter_if #(
   parameter int NUM_REQ    = spring_engine_arbiter_pkg::NUM_REQ_DEF,
   parameter int NUM_NODES  = spring_engine_arbiter_pkg::NUM_NODES_DEF,
   parameter int FORCE_SIZE = spring_engine_arbiter_pkg::FORCE_SIZE_DEF
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(NUM_NODES) + 1;

   logic [NUM_REQ-1:0]    req_in;
   logic [NUM_REQ-1:0]    grant_out;
   logic [IDX_W-1:0]      grant_idx_out;
   logic                  eng_start_out;
   logic                  eng_force_valid_in;
   logic [FORCE_SIZE-1:0] eng_force_x_in;
   logic [FORCE_SIZE-1:0] eng_force_y_in;
   logic [FORCE_SIZE-1:0] eng_axle_x_in;
   logic [FORCE_SIZE-1:0] eng_axle_y_in;
   logic                  eng_done_in;
   logic [NUM_REQ-1:0]    force_valid_out;
   logic [FORCE_SIZE-1:0] force_x_out;
   logic [FORCE_SIZE-1:0] force_y_out;
   logic [CNT_W-1:0]      node_idx_out;
   logic [FORCE_SIZE-1:0] axle_x_out;
   logic [FORCE_SIZE-1:0] axle_y_out;
   logic [NUM_REQ-1:0]    done_out;
   logic                  err_out;

   modport slave (
      input  req_in, eng_force_valid_in, eng_force_x_in, eng_force_y_in,
             eng_axle_x_in, eng_axle_y_in, eng_done_in,
      output grant_out, grant_idx_out, eng_start_out, force_valid_out,
             force_x_out, force_y_out, node_idx_out, axle_x_out, axle_y_out,
             done_out, err_out
   );

   modport master (
      output req_in, eng_force_valid_in, eng_force_x_in, eng_force_y_in,
             eng_axle_x_in, eng_axle_y_in, eng_done_in,
      input  grant_out, grant_idx_out, eng_start_out, force_valid_out,
             force_x_out, force_y_out, node_idx_out, axle_x_out, axle_y_out,
             done_out, err_out
   );

endinterface

// File: rtl/spring_engine_arbiter_rr_picker.sv
// Round-robin first-set search: scans req_in starting at ptr_in and wrapping,
// returning the winner as one-hot and as a binary index.
module spring_engine_arbiter_rr_picker #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_in,
   input  logic [IDX_W-1:0]   ptr_in,
   output logic [NUM_REQ-1:0] grant_out,
   output logic [IDX_W-1:0]   idx_out,
   output logic               any_out
);

   localparam logic [IDX_W:0] NREQ_EXT = (IDX_W + 1)'(NUM_REQ);

   logic [IDX_W:0] pos_s;
   logic           take_s;

   // Walk candidates in priority order; the first requester seen wins.
   always_comb begin
      grant_out = '0;
      idx_out   = '0;
      any_out   = 1'b0;
      pos_s     = '0;
      take_s    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos_s  = {1'b0, ptr_in} + (IDX_W + 1)'(i);
         pos_s  = (pos_s >= NREQ_EXT) ? (pos_s - NREQ_EXT) : pos_s;
         take_s = ~any_out & req_in[pos_s[IDX_W-1:0]];
         grant_out[pos_s[IDX_W-1:0]] = take_s;
         idx_out = take_s ? pos_s[IDX_W-1:0] : idx_out;
         any_out = any_out | take_s;
      end
   end

endmodule

// File: rtl/spring_engine_arbiter.sv
// Shares one spring-force engine among NUM_REQ bodies: round-robin grant,
// start pulse, force/axle routing to the owner, and a hung-engine watchdog.
module spring_engine_arbiter
   import spring_engine_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = NUM_REQ_DEF,
   parameter int NUM_NODES      = NUM_NODES_DEF,
   parameter int FORCE_SIZE     = FORCE_SIZE_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input logic                      clk_in,
   input logic                      rst_in,
   spring_engine_arbiter_if.slave   arb_bus
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(NUM_NODES) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_NODES + 1);
   localparam logic [CNT_W-1:0] CNT_EXP = CNT_W'(NUM_NODES);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   arb_state_t            state_r;
   logic [IDX_W-1:0]      ptr_r;
   logic [NUM_REQ-1:0]    grant_r;
   logic [IDX_W-1:0]      grant_idx_r;
   logic                  eng_start_r;
   logic [NUM_REQ-1:0]    force_valid_r;
   logic [FORCE_SIZE-1:0] force_x_r;
   logic [FORCE_SIZE-1:0] force_y_r;
   logic [CNT_W-1:0]      node_idx_r;
   logic [FORCE_SIZE-1:0] axle_x_r;
   logic [FORCE_SIZE-1:0] axle_y_r;
   logic [NUM_REQ-1:0]    done_r;
   logic                  err_r;
   logic [CNT_W-1:0]      sample_cnt_r;
   logic [TO_W-1:0]       to_cnt_r;

   logic [NUM_REQ-1:0]    req_mask_s;
   logic [NUM_REQ-1:0]    pick_grant_s;
   logic [IDX_W-1:0]      pick_idx_s;
   logic                  pick_any_s;

   // The finishing owner still holds req_in while its done pulse is out; hide it so it is not re-granted.
   assign req_mask_s = arb_bus.req_in & ~done_r;

   spring_engine_arbiter_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req_in    (req_mask_s),
      .ptr_in    (ptr_r),
      .grant_out (pick_grant_s),
      .idx_out   (pick_idx_s),
      .any_out   (pick_any_s)
   );

   // Job sequencing, sample routing, watchdog and all registered outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_r       <= IDLE;
         ptr_r         <= '0;
         grant_r       <= '0;
         grant_idx_r   <= '0;
         eng_start_r   <= 1'b0;
         force_valid_r <= '0;
         force_x_r     <= '0;
         force_y_r     <= '0;
         node_idx_r    <= '0;
         axle_x_r      <= '0;
         axle_y_r      <= '0;
         done_r        <= '0;
         err_r         <= 1'b0;
         sample_cnt_r  <= '0;
         to_cnt_r      <= '0;
      end else begin
         eng_start_r   <= 1'b0;
         force_valid_r <= '0;
         done_r        <= '0;
         err_r         <= 1'b0;
         case (state_r)
            IDLE: begin
               if (pick_any_s) begin
                  grant_r      <= pick_grant_s;
                  grant_idx_r  <= pick_idx_s;
                  sample_cnt_r <= '0;
                  to_cnt_r     <= '0;
                  state_r      <= START;
               end
            end
            START: begin
               eng_start_r <= 1'b1;
               to_cnt_r    <= '0;
               state_r     <= BUSY;
            end
            BUSY: begin
               if (arb_bus.eng_force_valid_in) begin
                  force_x_r     <= arb_bus.eng_force_x_in;
                  force_y_r     <= arb_bus.eng_force_y_in;
                  force_valid_r <= grant_r;
                  node_idx_r    <= sample_cnt_r;
                  if (sample_cnt_r != CNT_MAX) begin
                     sample_cnt_r <= sample_cnt_r + CNT_W'(1);
                  end
               end
               // A done on the last allowed cycle still counts as on time.
               if (arb_bus.eng_done_in) begin
                  axle_x_r <= arb_bus.eng_axle_x_in;
                  axle_y_r <= arb_bus.eng_axle_y_in;
                  state_r  <= FINISH;
               end else if (to_cnt_r == TO_LAST) begin
                  done_r      <= grant_r;
                  err_r       <= 1'b1;
                  axle_x_r    <= '0;
                  axle_y_r    <= '0;
                  ptr_r       <= IDX_W'(wrap_inc(int'(grant_idx_r), NUM_REQ));
                  grant_r     <= '0;
                  grant_idx_r <= '0;
                  state_r     <= IDLE;
               end else begin
                  to_cnt_r <= to_cnt_r + TO_W'(1);
               end
            end
            FINISH: begin
               done_r      <= grant_r;
               err_r       <= (sample_cnt_r != CNT_EXP);
               ptr_r       <= IDX_W'(wrap_inc(int'(grant_idx_r), NUM_REQ));
               grant_r     <= '0;
               grant_idx_r <= '0;
               state_r     <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign arb_bus.grant_out       = grant_r;
   assign arb_bus.grant_idx_out   = grant_idx_r;
   assign arb_bus.eng_start_out   = eng_start_r;
   assign arb_bus.force_valid_out = force_valid_r;
   assign arb_bus.force_x_out     = force_x_r;
   assign arb_bus.force_y_out     = force_y_r;
   assign arb_bus.node_idx_out    = node_idx_r;
   assign arb_bus.axle_x_out      = axle_x_r;
   assign arb_bus.axle_y_out      = axle_y_r;
   assign arb_bus.done_out        = done_r;
   assign arb_bus.err_out         = err_r;

endmodule

// File: tb/tb_spring_engine_arbiter.sv
// Directed + randomized bench for spring_engine_arbiter against a job-level
// reference model (round-robin owner choice, sample counting, timeout timing).
module tb_spring_engine_arbiter;
   import spring_engine_arbiter_pkg::*;

   localparam int NREQ    = 2;
   localparam int NNODES  = 10;
   localparam int FSIZE   = 8;
   localparam int TIMEOUT = 64;

   logic clk_in = 1'b0;
   logic rst_in;
   int   checks   = 0;
   int   failures = 0;
   int   model_ptr = 0;
   logic [FSIZE-1:0] m_ax = '0;
   logic [FSIZE-1:0] m_ay = '0;

   spring_engine_arbiter_if #(.NUM_REQ(NREQ), .NUM_NODES(NNODES), .FORCE_SIZE(FSIZE)) arb_if ();

   spring_engine_arbiter #(
      .NUM_REQ(NREQ), .NUM_NODES(NNODES), .FORCE_SIZE(FSIZE), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .arb_bus (arb_if.slave)
   );

   always #5 clk_in = ~clk_in;

   task automatic step();
      @(negedge clk_in);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete job from request to done pulse, checked against the model.
   task automatic run_job(input logic [1:0] req, input logic [1:0] req_after, input int nsamp,
                          input bit hang, input bit simul, input logic [7:0] ax, input logic [7:0] ay);
      int owner;
      int cyc;
      int gap;
      int exp_idx;
      bit got;
      logic [1:0] oh;
      logic [7:0] fx;
      logic [7:0] fy;
      owner = -1;
      for (int i = 0; i < NREQ; i++) begin
         if (owner < 0 && req[(model_ptr + i) % NREQ]) owner = (model_ptr + i) % NREQ;
      end
      oh = '0;
      oh[owner] = 1'b1;
      arb_if.req_in = req;
      got = 1'b0;
      for (int w = 0; w < 8; w++) begin
         if (arb_if.grant_out != 2'b00) begin
            got = 1'b1;
            break;
         end
         step();
      end
      chk("grant_wait", 32'(got), 32'd1);
      if (!got) return;
      chk("grant", 32'(arb_if.grant_out), 32'(oh));
      chk("grant_idx", 32'(arb_if.grant_idx_out), 32'(owner));
      chk("start_before_grant", 32'(arb_if.eng_start_out), 32'd0);
      chk("axle_hold", {16'd0, arb_if.axle_x_out, arb_if.axle_y_out}, {16'd0, m_ax, m_ay});
      step();
      chk("start", 32'(arb_if.eng_start_out), 32'd1);
      chk("grant_stable", 32'(arb_if.grant_out), 32'(oh));
      cyc = 0;
      exp_idx = 0;
      for (int k = 0; k < nsamp; k++) begin
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin
            step();
            cyc++;
            chk("valid_idle", 32'(arb_if.force_valid_out), 32'd0);
         end
         fx = 8'($urandom);
         fy = 8'($urandom);
         arb_if.eng_force_valid_in = 1'b1;
         arb_if.eng_force_x_in = fx;
         arb_if.eng_force_y_in = fy;
         if (k == nsamp - 1 && simul && !hang) begin
            arb_if.eng_done_in = 1'b1;
            arb_if.eng_axle_x_in = ax;
            arb_if.eng_axle_y_in = ay;
         end
         step();
         cyc++;
         arb_if.eng_force_valid_in = 1'b0;
         arb_if.eng_done_in = 1'b0;
         exp_idx = (k > NNODES + 1) ? NNODES + 1 : k;
         chk("force_valid", 32'(arb_if.force_valid_out), 32'(oh));
         chk("force_xy", {16'd0, arb_if.force_x_out, arb_if.force_y_out}, {16'd0, fx, fy});
         chk("node_idx", 32'(arb_if.node_idx_out), 32'(exp_idx));
      end
      if (!hang) begin
         if (!(simul && nsamp > 0)) begin
            arb_if.eng_done_in = 1'b1;
            arb_if.eng_axle_x_in = ax;
            arb_if.eng_axle_y_in = ay;
            step();
            arb_if.eng_done_in = 1'b0;
         end
         chk("done_early", 32'(arb_if.done_out), 32'd0);
         chk("start_pulse_len", 32'(arb_if.eng_start_out), 32'd0);
         step();
         chk("done", 32'(arb_if.done_out), 32'(oh));
         chk("err", 32'(arb_if.err_out), 32'(nsamp != NNODES));
         chk("axle", {16'd0, arb_if.axle_x_out, arb_if.axle_y_out}, {16'd0, ax, ay});
         chk("grant_released", 32'(arb_if.grant_out), 32'd0);
         if (nsamp > 0) chk("node_idx_last", 32'(arb_if.node_idx_out), 32'(exp_idx));
         m_ax = ax;
         m_ay = ay;
      end else begin
         while (cyc < TIMEOUT - 1) begin
            step();
            cyc++;
         end
         chk("timeout_early", 32'(arb_if.done_out), 32'd0);
         step();
         chk("timeout_done", 32'(arb_if.done_out), 32'(oh));
         chk("timeout_err", 32'(arb_if.err_out), 32'd1);
         chk("timeout_axle", {16'd0, arb_if.axle_x_out, arb_if.axle_y_out}, 32'd0);
         m_ax = '0;
         m_ay = '0;
      end
      model_ptr = (owner + 1) % NREQ;
      arb_if.req_in = req_after;
      step();
      chk("done_pulse_len", 32'(arb_if.done_out), 32'd0);
      chk("err_pulse_len", 32'(arb_if.err_out), 32'd0);
   endtask

   initial begin
      logic [1:0] cur_req;
      logic [1:0] nxt_req;
      int ns;
      bit hg;
      rst_in = 1'b0;
      arb_if.req_in = 2'b11;
      arb_if.eng_force_valid_in = 1'b0;
      arb_if.eng_force_x_in = '0;
      arb_if.eng_force_y_in = '0;
      arb_if.eng_axle_x_in = '0;
      arb_if.eng_axle_y_in = '0;
      arb_if.eng_done_in = 1'b0;

      // Reset held with both bodies requesting.
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_grant", 32'(arb_if.grant_out), 32'd0);
         chk("rst_start", 32'(arb_if.eng_start_out), 32'd0);
         chk("rst_misc", {arb_if.done_out, arb_if.err_out, arb_if.force_valid_out, arb_if.node_idx_out,
                          arb_if.grant_idx_out}, 32'd0);
         chk("rst_data", {arb_if.force_x_out, arb_if.force_y_out, arb_if.axle_x_out, arb_if.axle_y_out}, 32'd0);
      end
      arb_if.req_in = 2'b00;
      rst_in = 1'b1;
      step();

      // Single request, full job, axle (-5,3).
      run_job(2'b01, 2'b00, NNODES, 1'b0, 1'b0, 8'hFB, 8'h03);
      // Hung engine on body 1.
      run_job(2'b10, 2'b00, 3, 1'b1, 1'b0, 8'h11, 8'h22);
      // Contention held over four jobs: expect 0,1,0,1.
      for (int j = 0; j < 4; j++) begin
         chk("rr_order_ptr", 32'(model_ptr), 32'(j % 2));
         run_job(2'b11, (j == 3) ? 2'b00 : 2'b11, NNODES, 1'b0, j[0], 8'($urandom), 8'($urandom));
      end
      // Short job: nine samples.
      run_job(2'b01, 2'b00, NNODES - 1, 1'b0, 1'b0, 8'h7F, 8'h80);

      // Mid-job reset while body 1 owns the engine.
      arb_if.req_in = 2'b11;
      for (int w = 0; w < 8 && arb_if.grant_out == 2'b00; w++) step();
      chk("mid_grant", 32'(arb_if.grant_out), 32'd2);
      step();
      for (int k = 0; k < 4; k++) begin
         arb_if.eng_force_valid_in = 1'b1;
         arb_if.eng_force_x_in = 8'(k);
         step();
      end
      rst_in = 1'b0;
      step();
      arb_if.eng_force_valid_in = 1'b0;
      chk("mid_rst_grant", 32'(arb_if.grant_out), 32'd0);
      chk("mid_rst_done", {arb_if.done_out, arb_if.err_out, arb_if.force_valid_out}, 32'd0);
      rst_in = 1'b1;
      arb_if.req_in = 2'b00;
      step();
      chk("mid_rst_no_done", 32'(arb_if.done_out), 32'd0);
      model_ptr = 0;
      m_ax = '0;
      m_ay = '0;
      run_job(2'b11, 2'b00, NNODES, 1'b0, 1'b0, 8'h5A, 8'hA5);

      // Randomized jobs; the next request pattern is applied as each job ends.
      cur_req = 2'($urandom_range(1, 3));
      for (int j = 0; j < 14; j++) begin
         nxt_req = (j == 13) ? 2'b00 : 2'($urandom_range(1, 3));
         hg = ($urandom_range(0, 6) == 0);
         ns = hg ? $urandom_range(0, NNODES) : $urandom_range(0, NNODES + 3);
         run_job(cur_req, nxt_req, ns, hg, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
         cur_req = nxt_req;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
